// File: rtl/fifosync_flex_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifosync_flex_if                                                   |
// | Producer/consumer bundle for the fifosync_flex synchronous FIFO.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fifosync_flex_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          err_clr;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifosync_flex.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifosync_flex                                                      |
// | Single-clock FIFO: registered or FWFT read, programmable almost    |
// | thresholds, fill level, write-while-full pass-through.             |
// | Optional sticky error flags: define FIFOSYNC_FLEX_ERR_EN.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fifosync_flex #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int FWFT   = 0,
    parameter int AFULL  = 12,
    parameter int AEMPTY = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fifosync_flex_if.slave  bus
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   c_depth  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_afull  = (AW+1)'(AFULL);
    localparam logic [AW:0]   c_aempty = (AW+1)'(AEMPTY);
    localparam logic [AW:0]   c_lvl_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_level_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_rd_acc;
    logic          w_wr_acc;

    assign w_full   = (r_level == c_depth);
    assign w_empty  = (r_level == '0);
    assign w_rd_acc = bus.rd_en && !w_empty;
    // A full FIFO still takes a write when a pop frees a slot this cycle.
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + c_lvl_one;
            2'b01:   w_level_nxt = r_level - c_lvl_one;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Storage is not reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_level >= c_afull);
    assign bus.almost_empty = (r_level <= c_aempty);
    assign bus.level        = r_level;

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data  = r_mem[r_rd_ptr];
            assign bus.rd_valid = !w_empty;
        end else begin : g_reg_read
            logic [DW-1:0] r_rd_data;
            logic          r_rd_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_rd_data  <= r_mem[r_rd_ptr];
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b0;
                end
            end

            assign bus.rd_data  = r_rd_data;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

`ifdef FIFOSYNC_FLEX_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A fresh error in the err_clr cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    logic w_err_clr_unused;
    assign w_err_clr_unused = bus.err_clr;
    assign bus.overflow     = 1'b0;
    assign bus.underflow    = 1'b0;
`endif

endmodule
`default_nettype wire
